seq_divider: RTL and testbench

//  Multicycle restoring divider for DIV/DIVU in the EX stage of mips_pipeline.

---
 rtl/seq_divider.sv | 170 +++++++++++++++++
 tb/tb_seq_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multicycle restoring divider for DIV/DIVU in the EX stage.
// One quotient bit is produced per cycle. When the division finishes, the
// remainder appears on hi, the quotient on lo, and done pulses for one cycle.
// Optional feature: define DIV_EARLY_OUT_EN to skip the iteration phase when
// |dividend| < |divisor| (with divisor != 0).
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        request, accepted only in IDLE
//   is_signed    1 = DIV (two's complement), 0 = DIVU
//   dividend     numerator, sampled on the accepting edge
//   divisor      denominator, sampled on the accepting edge
//   busy         high while a division is in flight
//   done         one-cycle pulse: hi/lo/div_by_zero valid
//   hi           remainder
//   lo           quotient
//   div_by_zero  divisor was zero (valid with done, held until the next done)
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   b_abs, b_abs_nxt;
   logic [WIDTH-1:0]   q, q_nxt;
   logic [WIDTH-1:0]   rem, rem_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               neg_q, neg_q_nxt;
   logic               neg_r, neg_r_nxt;
   logic               dbz, dbz_nxt;
   logic [WIDTH-1:0]   raw_a, raw_a_nxt;
   logic               busy_nxt, done_nxt, div_by_zero_nxt;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_abs_in, b_abs_in;
   logic [WIDTH:0]     shifted;

   // Operand sign and magnitude conditioning
   always_comb begin
      a_neg    = is_signed & dividend[WIDTH-1];
      b_neg    = is_signed & divisor[WIDTH-1];
      a_abs_in = a_neg ? -dividend : dividend;
      b_abs_in = b_neg ? -divisor : divisor;
      // One extra bit so the compare against |b| cannot overflow
      shifted  = {rem, q[WIDTH-1]};
   end

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         b_abs       <= '0;
         q           <= '0;
         rem         <= '0;
         count       <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dbz         <= 1'b0;
         raw_a       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_nxt;
         b_abs       <= b_abs_nxt;
         q           <= q_nxt;
         rem         <= rem_nxt;
         count       <= count_nxt;
         neg_q       <= neg_q_nxt;
         neg_r       <= neg_r_nxt;
         dbz         <= dbz_nxt;
         raw_a       <= raw_a_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         hi          <= hi_nxt;
         lo          <= lo_nxt;
         div_by_zero <= div_by_zero_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt       = state;
      b_abs_nxt       = b_abs;
      q_nxt           = q;
      rem_nxt         = rem;
      count_nxt       = count;
      neg_q_nxt       = neg_q;
      neg_r_nxt       = neg_r;
      dbz_nxt         = dbz;
      raw_a_nxt       = raw_a;
      busy_nxt        = busy;
      done_nxt        = 1'b0;
      hi_nxt          = hi;
      lo_nxt          = lo;
      div_by_zero_nxt = div_by_zero;

      case (state)
         IDLE: begin
            if (start) begin
               neg_q_nxt = a_neg ^ b_neg;
               neg_r_nxt = a_neg;
               b_abs_nxt = b_abs_in;
               q_nxt     = a_abs_in;
               rem_nxt   = '0;
               count_nxt = '0;
               dbz_nxt   = (divisor == '0);
               raw_a_nxt = dividend;
               busy_nxt  = 1'b1;
               state_nxt = CALC;
`ifdef DIV_EARLY_OUT_EN
               // Quotient is already known to be zero; remainder is |a|
               if ((divisor != '0) && (a_abs_in < b_abs_in)) begin
                  q_nxt     = '0;
                  rem_nxt   = a_abs_in;
                  state_nxt = FIX;
               end
`endif
            end
         end

         CALC: begin
            q_nxt   = {q[WIDTH-2:0], 1'b0};
            rem_nxt = shifted[WIDTH-1:0];
            if (shifted >= {1'b0, b_abs}) begin
               rem_nxt  = shifted[WIDTH-1:0] - b_abs;
               q_nxt[0] = 1'b1;
            end
            count_nxt = count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) state_nxt = FIX;
         end

         FIX: begin
            busy_nxt        = 1'b0;
            done_nxt        = 1'b1;
            div_by_zero_nxt = dbz;
            state_nxt       = IDLE;
            if (dbz) begin
               // Divide by zero reports the raw dividend, no sign fixup
               lo_nxt = '1;
               hi_nxt = raw_a;
            end else begin
               lo_nxt = neg_q ? -q : q;
               hi_nxt = neg_r ? -rem : rem;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed, table-driven bench for seq_divider (WIDTH=32).
module tb_seq_divider;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          div_by_zero;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          sg;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  lo;
      logic [W-1:0]  hi;
      logic          dbz;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Expected number of edges after the accepting edge until done is seen
   function automatic int exp_lat(input vec_t v);
      int lat;
      lat = W + 1;
`ifdef DIV_EARLY_OUT_EN
      begin
         logic [W-1:0] aa, bb;
         aa = (v.sg && v.a[W-1]) ? -v.a : v.a;
         bb = (v.sg && v.b[W-1]) ? -v.b : v.b;
         if (v.b != '0 && aa < bb) lat = 1;
      end
`endif
      return lat;
   endfunction

   task automatic run_div(input vec_t v, input bit hold_chk, input string tag);
      int n;
      @(negedge clk);
      start     = 1'b1;
      is_signed = v.sg;
      dividend  = v.a;
      divisor   = v.b;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, " busy_after_start"}, W'(busy), W'(1'b1));
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (done) break;
      end
      chk({tag, " latency"}, W'(n), W'(exp_lat(v)));
      chk({tag, " lo"}, lo, v.lo);
      chk({tag, " hi"}, hi, v.hi);
      chk({tag, " dbz"}, W'(div_by_zero), W'(v.dbz));
      chk({tag, " busy_with_done"}, W'(busy), W'(1'b0));
      if (hold_chk) begin
         @(posedge clk);
         #1;
         chk({tag, " done_one_cycle"}, W'(done), W'(1'b0));
         chk({tag, " lo_held"}, lo, v.lo);
      end
   endtask

   initial begin
      int dones;
      vec_t v;

      tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
      tbl[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
      tbl[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
      tbl[4]  = '{1'b0, 32'd6,          32'd3,          32'd2,          32'd0,          1'b0};
      tbl[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
      tbl[6]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
      tbl[7]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD,   1'b0};
      tbl[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
      tbl[9]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
      tbl[10] = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0};
      tbl[11] = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
      tbl[12] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
      tbl[13] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};

      rst       = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #1;
      chk("reset busy", W'(busy), '0);
      chk("reset done", W'(done), '0);
      chk("reset hi", hi, '0);
      chk("reset lo", lo, '0);
      chk("reset dbz", W'(div_by_zero), '0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_div(tbl[i], 1'b1, $sformatf("vec%0d", i));
      end

      // Start asserted in the done cycle is accepted
      run_div(tbl[0], 1'b0, "b2b_first");
      run_div(tbl[4], 1'b1, "b2b_second");

      // Start pulsed mid-CALC is ignored; exactly one done
      @(negedge clk);
      start = 1'b1; is_signed = 1'b1; dividend = 32'h80000000; divisor = 32'hFFFFFFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd1; divisor = 32'd1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      chk("midcalc done_count", W'(dones), W'(1));
      chk("midcalc lo", lo, 32'h80000000);
      chk("midcalc hi", hi, 32'd0);

      // Reset mid-operation aborts with no done
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort busy", W'(busy), '0);
      chk("abort lo", lo, '0);
      chk("abort hi", hi, '0);
      chk("abort dbz", W'(div_by_zero), '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      chk("abort no_done", W'(dones), '0);

      v = '{1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0};
      run_div(v, 1'b1, "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
